// File: rtl/rst_sequencer_pkg.sv
// rst_sequencer_pkg: state encoding and counter-width helper shared by the sequencer and its bench
package rst_sequencer_pkg;
    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_HOLD      = 3'd1;
    localparam logic [2:0] ST_REL_DBG   = 3'd2;
    localparam logic [2:0] ST_REL_CORE  = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_SOFT_HOLD = 3'd5;
    localparam logic [2:0] ST_SOFT_WAIT = 3'd6;
    localparam logic [2:0] ST_SOFT_REL  = 3'd7;

    function automatic int cnt_width(input int h, input int s, input int w);
        int m;
        m = (h > s) ? h : s;
        m = (m > w) ? m : w;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/rst_sequencer_timer.sv
// seq_timer: loadable down-counter that saturates at zero, with zero flag
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;

    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged debug/core/peripheral reset release plus soft-reset handshake;
// define RST_SEQUENCER_WDOG_EN to add the watchdog (wdog_kick/wdog_fired)
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDOG_CYCLES    = 1 << 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sreq,
`ifdef RST_SEQUENCER_WDOG_EN
    input  logic wdog_kick,
    output logic wdog_fired,
`endif
    output logic rst_n_dbg,
    output logic rst_n_core,
    output logic rst_n_periph,
    output logic sack,
    output logic busy
);
    localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, WDOG_CYCLES);

    logic [2:0]    state_q, state_d;
    logic          held_q, held_d;
    logic          dbg_q, core_q, periph_q, sack_q, busy_q;
    logic          tmr_zero, wfire;
    logic [CW-1:0] tmr_val;

`ifdef RST_SEQUENCER_WDOG_EN
    logic wdog_zero, fired_q;

    seq_timer #(.W(CW)) u_wdog (
        .clk(clk),
        .rst_n(rst_n),
        .load_i((state_d == ST_RUN && state_q != ST_RUN) || (state_q == ST_RUN && wdog_kick)),
        .dec_i(state_q == ST_RUN),
        .val_i(CW'(WDOG_CYCLES - 1)),
        .zero_o(wdog_zero)
    );

    assign wfire = state_q == ST_RUN && wdog_zero && !wdog_kick;

    always_ff @(posedge clk) fired_q <= rst_n && (fired_q || wfire);

    assign wdog_fired = fired_q;
`else
    assign wfire = 1'b0;
`endif

    seq_timer #(.W(CW)) u_tmr (
        .clk(clk),
        .rst_n(rst_n),
        .load_i(state_d != state_q),
        .dec_i(1'b1),
        .val_i(tmr_val),
        .zero_o(tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     state_d = ST_HOLD;
            ST_HOLD:      state_d = tmr_zero ? ST_REL_DBG : state_q;
            ST_REL_DBG:   state_d = tmr_zero ? ST_REL_CORE : state_q;
            ST_REL_CORE:  state_d = tmr_zero ? ST_RUN : state_q;
            ST_RUN:       state_d = (sreq || wfire) ? ST_SOFT_HOLD : state_q;
            ST_SOFT_HOLD: state_d = tmr_zero ? ST_SOFT_WAIT : state_q;
            ST_SOFT_WAIT: state_d = sreq ? state_q : ST_SOFT_REL;
            ST_SOFT_REL:  state_d = tmr_zero ? ST_REL_CORE : state_q;
            default:      state_d = ST_RESET;
        endcase
    end

    always_comb tmr_val = (state_d == ST_HOLD || state_d == ST_SOFT_HOLD) ? CW'(HOLD_CYCLES - 1) :
                          (state_d == ST_REL_DBG || state_d == ST_REL_CORE || state_d == ST_SOFT_REL) ?
                          CW'(STAGGER_CYCLES - 1) : '0;

    // sreq still high when the hold ends means a real handshake: keep sack until periph is released
    always_comb held_d = (state_q == ST_SOFT_HOLD) ? sreq : held_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            held_q   <= 1'b0;
            dbg_q    <= 1'b0;
            core_q   <= 1'b0;
            periph_q <= 1'b0;
            sack_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            dbg_q    <= state_d != ST_RESET && state_d != ST_HOLD;
            core_q   <= state_d == ST_REL_CORE || state_d == ST_RUN;
            periph_q <= state_d == ST_RUN;
            sack_q   <= state_d == ST_SOFT_WAIT ||
                        (held_q && (state_d == ST_SOFT_REL || state_d == ST_REL_CORE));
            busy_q   <= state_d != ST_RUN;
        end
    end

    assign rst_n_dbg    = dbg_q;
    assign rst_n_core   = core_q;
    assign rst_n_periph = periph_q;
    assign sack         = sack_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: timestamp-based reference model feeding a scoreboard queue, compared each cycle by a monitor
module tb_rst_sequencer;
    localparam int H = 16;
    localparam int S = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sreq = 1'b0;
    logic wdog_kick = 1'b0;
    logic rst_n_dbg, rst_n_core, rst_n_periph, sack, busy, fired_sig;

    int errors = 0;
    int checks = 0;
    int kick_mode = 1;
    int kick_per = 16;
    int tcount = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    rst_sequencer #(.HOLD_CYCLES(H), .STAGGER_CYCLES(S), .WDOG_CYCLES(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sreq(sreq),
`ifdef RST_SEQUENCER_WDOG_EN
        .wdog_kick(wdog_kick),
        .wdog_fired(fired_sig),
`endif
        .rst_n_dbg(rst_n_dbg),
        .rst_n_core(rst_n_core),
        .rst_n_periph(rst_n_periph),
        .sack(sack),
        .busy(busy)
    );

`ifndef RST_SEQUENCER_WDOG_EN
    assign fired_sig = 1'b0;
`endif

    initial begin
        int n, mode, t0, ts, rel, last;
        bit held, fired, fire, e_dbg, e_core, e_per, e_sack, e_busy;
        n = 0; mode = 0; t0 = 0; ts = 0; rel = -1; last = 0;
        held = 0; fired = 0;
        forever begin
            @(posedge clk);
            n++;
            fire = 0;
            if (!rst_n) begin
                mode = 0;
                fired = 0;
            end else if (mode == 0) begin
                mode = 1;
                t0 = n;
            end else if (mode == 1) begin
                if (n - t0 == H + 2 * S) begin
                    mode = 2;
                    last = n;
                end
            end else if (mode == 2) begin
`ifdef RST_SEQUENCER_WDOG_EN
                if (wdog_kick) last = n;
                else if (n - last >= W) begin
                    fire = 1;
                    fired = 1;
                end
`endif
                if (sreq || fire) begin
                    mode = 3;
                    ts = n;
                    rel = -1;
                end
            end else if (rel < 0) begin
                if (n - ts == H) held = sreq;
                else if (n - ts > H && !sreq) rel = n;
            end else if (n - rel == 2 * S) begin
                mode = 2;
                last = n;
            end
            e_dbg = 0; e_core = 0; e_per = 0; e_sack = 0; e_busy = 1;
            if (mode == 1) begin
                e_dbg = n - t0 >= H;
                e_core = n - t0 >= H + S;
            end else if (mode == 2) begin
                e_dbg = 1; e_core = 1; e_per = 1; e_busy = 0;
            end else if (mode == 3) begin
                e_dbg = 1;
                if (rel < 0) e_sack = n - ts >= H;
                else begin
                    e_core = n - rel >= S;
                    e_sack = held;
                end
            end
            exp_q.push_back({e_dbg, e_core, e_per, e_sack, e_busy, fired});
        end
    end

    initial begin
        logic [5:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {rst_n_dbg, rst_n_core, rst_n_periph, sack, busy, fired_sig};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t dbg/core/periph/sack/busy/fired got=%b exp=%b", $time, a, e);
                end
            end
        end
    end

    initial begin
        logic r;
        forever begin
            @(posedge clk);
            r = rst_n;
            @(negedge clk);
            if (!r) begin
                checks++;
                if ({rst_n_dbg, rst_n_core, rst_n_periph, sack, busy, fired_sig} !== 6'b000010) begin
                    errors++;
                    $display("FAIL reset state t=%0t got=%b exp=000010", $time,
                             {rst_n_dbg, rst_n_core, rst_n_periph, sack, busy, fired_sig});
                end
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL timeout: stimulus did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic step(input logic r, input logic s);
        @(negedge clk);
        rst_n = r;
        sreq = s;
        wdog_kick = (kick_mode == 1) ? (tcount % kick_per == 0) :
                    (kick_mode == 2) ? ($urandom_range(0, 39) == 0) : 1'b0;
        tcount++;
    endtask

    initial begin
        repeat (5) step(0, 0);
        repeat (40) step(1, 0);
        repeat (40) step(1, 1);
        repeat (30) step(1, 0);
        repeat (3) step(0, 0);
        repeat (10) step(1, 0);
        repeat (50) step(1, 1);
        repeat (30) step(1, 0);
        repeat (22) step(1, 1);
        step(0, 1);
        repeat (40) step(1, 0);
        step(1, 1);
        repeat (40) step(1, 0);
`ifdef RST_SEQUENCER_WDOG_EN
        kick_per = 50;
        repeat (300) step(1, 0);
        kick_mode = 0;
        repeat (160) step(1, 0);
        step(0, 0);
        kick_mode = 1;
        kick_per = 16;
        repeat (40) step(1, 0);
`endif
        kick_mode = 2;
        for (int i = 0; i < 60; i++) begin
            int hi, lo;
            hi = $urandom_range(1, 50);
            lo = $urandom_range(1, 60);
            repeat (hi) step($urandom_range(0, 199) != 0, 1);
            repeat (lo) step($urandom_range(0, 199) != 0, 0);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
